// File: rtl/uart_rx_cfg_if.sv
// Receive-side byte stream interface of uart_rx_cfg: received word with its
// error sidebands, a valid/ready handshake and the one-clock event pulses.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_error;
  logic                 frame_error;
  logic                 overrun;
  logic                 break_det;

  // Receiver side: produces words and events, observes consumer readiness.
  modport master (
    output rx_data,
    output rx_valid,
    output parity_error,
    output frame_error,
    output overrun,
    output break_det,
    input  rx_ready
  );

  // Consumer side: takes words and events, signals readiness.
  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_error,
    input  frame_error,
    input  overrun,
    input  break_det,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled line, 3-sample majority per bit,
// false-start rejection, optional parity, 1 or 2 stop bits, break detection
// and a single-entry output register with overrun reporting.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          uart_rxd,
  uart_rx_cfg_if.master rx_if
);

  localparam int TICK_DIV = CLK_FREQ / (UART_BPS * OVERSAMPLE);
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W    = 4;
  localparam int SMP_A    = OVERSAMPLE / 2 - 1;
  localparam int SMP_B    = OVERSAMPLE / 2;
  localparam int SMP_C    = OVERSAMPLE / 2 + 1;

  generate
    if (TICK_DIV < 1) begin : g_bad_tick
      $error("uart_rx_cfg: CLK_FREQ too low for UART_BPS*OVERSAMPLE");
    end
    if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
      $error("uart_rx_cfg: OVERSAMPLE must be even and >= 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_db
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_par
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY_ST = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_t;

  // Expected parity bit for a data word; odd adds the inversion.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t               state_r, state_nxt;
  logic [2:0]           sync_r;
  logic [TICK_W-1:0]    tick_cnt_r;
  logic [OS_W-1:0]      os_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic                 smp_a_r, smp_b_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 par_bit_r;
  logic                 stop_err_r, stop_zero_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r, parity_error_r, frame_error_r, overrun_r, break_r;

  logic line_s, fall_s, tick_s, samp_a_s, samp_b_s, samp_c_s, bit_end_s, maj_s;
  logic start_s, shift_s, par_ld_s, stop_smp_s, bit_inc_s, bit_clr_s, done_s, brk_s;
  logic par_err_s, frm_err_s, all_zero_s, last_stop_s;

  // Line as seen by the FSM is the middle stage; edge found against the last.
  assign line_s    = sync_r[1];
  assign fall_s    = sync_r[2] & ~sync_r[1];
  assign tick_s    = (tick_cnt_r == TICK_W'(TICK_DIV - 1));
  assign samp_a_s  = tick_s && (os_cnt_r == OS_W'(SMP_A));
  assign samp_b_s  = tick_s && (os_cnt_r == OS_W'(SMP_B));
  assign samp_c_s  = tick_s && (os_cnt_r == OS_W'(SMP_C));
  assign bit_end_s = tick_s && (os_cnt_r == OS_W'(OVERSAMPLE - 1));
  // Third sample is the live line value; majority is valid in that cycle.
  assign maj_s     = (smp_a_r & smp_b_r) | (smp_a_r & line_s) | (smp_b_r & line_s);

  assign last_stop_s = (bit_cnt_r == BIT_W'(STOP_BITS - 1));
  assign par_err_s   = (PARITY != 0) && (par_bit_r != calc_parity(data_r, (PARITY == 1)));
  assign frm_err_s   = stop_err_r | ~maj_s;
  assign all_zero_s  = (data_r == {DATA_BITS{1'b0}}) && ((PARITY == 0) || !par_bit_r) &&
                       stop_zero_r && !maj_s;

  // Three-flop synchroniser, idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 3'b111;
    end else begin
      sync_r <= {sync_r[1:0], uart_rxd};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and per-cycle datapath strobes.
  always_comb begin
    state_nxt  = state_r;
    start_s    = 1'b0;
    shift_s    = 1'b0;
    par_ld_s   = 1'b0;
    stop_smp_s = 1'b0;
    bit_inc_s  = 1'b0;
    bit_clr_s  = 1'b0;
    done_s     = 1'b0;
    brk_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          state_nxt = START;
          start_s   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (samp_c_s && maj_s) begin
          state_nxt = IDLE;
        end else if (bit_end_s) begin
          state_nxt = DATA;
          bit_clr_s = 1'b1;
        end else begin
          state_nxt = START;
        end
      end
      DATA: begin
        if (samp_c_s) begin
          shift_s = 1'b1;
        end else begin
          shift_s = 1'b0;
        end
        if (bit_end_s && (bit_cnt_r == BIT_W'(DATA_BITS - 1))) begin
          state_nxt = (PARITY != 0) ? PARITY_ST : STOP;
          bit_clr_s = 1'b1;
        end else if (bit_end_s) begin
          bit_inc_s = 1'b1;
        end else begin
          state_nxt = DATA;
        end
      end
      PARITY_ST: begin
        if (samp_c_s) begin
          par_ld_s = 1'b1;
        end else begin
          par_ld_s = 1'b0;
        end
        if (bit_end_s) begin
          state_nxt = STOP;
          bit_clr_s = 1'b1;
        end else begin
          state_nxt = PARITY_ST;
        end
      end
      STOP: begin
        // The last stop bit completes at its majority point so a following
        // start bit can be caught without waiting for the bit to end.
        if (samp_c_s && last_stop_s) begin
          stop_smp_s = 1'b1;
          if (all_zero_s) begin
            brk_s     = 1'b1;
            state_nxt = BRK;
          end else begin
            done_s    = 1'b1;
            state_nxt = IDLE;
          end
        end else if (samp_c_s) begin
          stop_smp_s = 1'b1;
        end else begin
          state_nxt = STOP;
        end
        if (bit_end_s && !last_stop_s) begin
          bit_inc_s = 1'b1;
        end else begin
          bit_inc_s = 1'b0;
        end
      end
      BRK: begin
        if (line_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BRK;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Tick divider and in-bit sample counter; held at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      os_cnt_r   <= {OS_W{1'b0}};
    end else if ((state_r == IDLE) || start_s) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      os_cnt_r   <= {OS_W{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      os_cnt_r   <= bit_end_s ? {OS_W{1'b0}} : os_cnt_r + OS_W'(1);
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  // Frame datapath: samples, bit counter, shift register, parity and stop flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_a_r     <= 1'b1;
      smp_b_r     <= 1'b1;
      bit_cnt_r   <= {BIT_W{1'b0}};
      data_r      <= {DATA_BITS{1'b0}};
      par_bit_r   <= 1'b0;
      stop_err_r  <= 1'b0;
      stop_zero_r <= 1'b1;
    end else begin
      if (samp_a_s) smp_a_r <= line_s;
      if (samp_b_s) smp_b_r <= line_s;
      if (bit_clr_s) begin
        bit_cnt_r <= {BIT_W{1'b0}};
      end else if (bit_inc_s) begin
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end
      if (shift_s) data_r <= {maj_s, data_r[DATA_BITS-1:1]};
      if (par_ld_s) par_bit_r <= maj_s;
      if (start_s) begin
        stop_err_r  <= 1'b0;
        stop_zero_r <= 1'b1;
      end else if (stop_smp_s) begin
        stop_err_r  <= stop_err_r | ~maj_s;
        stop_zero_r <= stop_zero_r & ~maj_s;
      end
    end
  end

  // Output register: load on completion unless a held word is still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r      <= {DATA_BITS{1'b0}};
      rx_valid_r     <= 1'b0;
      parity_error_r <= 1'b0;
      frame_error_r  <= 1'b0;
      overrun_r      <= 1'b0;
      break_r        <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      break_r   <= brk_s;
      if (done_s && (!rx_valid_r || rx_if.rx_ready)) begin
        rx_data_r      <= data_r;
        parity_error_r <= par_err_s;
        frame_error_r  <= frm_err_s;
        rx_valid_r     <= 1'b1;
      end else if (done_s) begin
        overrun_r <= 1'b1;
      end else if (rx_valid_r && rx_if.rx_ready) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data      = rx_data_r;
  assign rx_if.rx_valid     = rx_valid_r;
  assign rx_if.parity_error = parity_error_r;
  assign rx_if.frame_error  = frame_error_r;
  assign rx_if.overrun      = overrun_r;
  assign rx_if.break_det    = break_r;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three receivers (8N1, 8E1, 8N2) on separate
// lines, a vector table for single frames and hand sequences for the corners.
module tb_uart_rx_cfg;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BPS      = 100_000;
  localparam int OS       = 16;
  localparam int BT       = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rxd = 3'b111;

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if2 ();

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(BPS), .OVERSAMPLE(OS), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[0]), .rx_if(if0));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(BPS), .OVERSAMPLE(OS), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[1]), .rx_if(if1));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(BPS), .OVERSAMPLE(OS), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[2]), .rx_if(if2));

  int         beats [3];
  int         ovr   [3];
  int         brk   [3];
  logic [7:0] ldata [3];
  logic       lpe   [3];
  logic       lfe   [3];

  int n_cmp  = 0;
  int n_fail = 0;

  // Record accepted words and event pulses away from the active edge.
  always @(negedge clk) begin
    if (if0.rx_valid && if0.rx_ready) begin
      beats[0] <= beats[0] + 1; ldata[0] <= if0.rx_data;
      lpe[0] <= if0.parity_error; lfe[0] <= if0.frame_error;
    end
    if (if1.rx_valid && if1.rx_ready) begin
      beats[1] <= beats[1] + 1; ldata[1] <= if1.rx_data;
      lpe[1] <= if1.parity_error; lfe[1] <= if1.frame_error;
    end
    if (if2.rx_valid && if2.rx_ready) begin
      beats[2] <= beats[2] + 1; ldata[2] <= if2.rx_data;
      lpe[2] <= if2.parity_error; lfe[2] <= if2.frame_error;
    end
    if (if0.overrun) ovr[0] <= ovr[0] + 1;
    if (if1.overrun) ovr[1] <= ovr[1] + 1;
    if (if2.overrun) ovr[2] <= ovr[2] + 1;
    if (if0.break_det) brk[0] <= brk[0] + 1;
    if (if1.break_det) brk[1] <= brk[1] + 1;
    if (if2.break_det) brk[2] <= brk[2] + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line 0: 8N1, line 1: 8E1 (pb = parity bit), line 2: 8N2 (s2 = second stop).
  task automatic send_frame(input int ln, input logic [7:0] d, input logic pb, input logic s2);
    logic [11:0] frm;
    int          n;
    frm = {3'b111, 8'h00, 1'b0};
    frm[8:1] = d;
    n = 10;
    if (ln == 1) begin
      frm[9] = pb; n = 11;
    end else if (ln == 2) begin
      frm[10] = s2; n = 11;
    end
    for (int i = 0; i < n; i++) begin
      rxd[ln] = frm[i];
      wait_clk(BT);
    end
    rxd[ln] = 1'b1;
  endtask

  typedef struct {
    int         ln;
    logic [7:0] d;
    logic       pb;
    logic       s2;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  vec_t vecs [10];

  // Send one frame and check a single delivered word with its flags.
  task automatic run_frame(input string nm, input int ln, input logic [7:0] d, input logic pb,
                           input logic s2, input logic [7:0] ed, input logic epe, input logic efe);
    int b0, k0;
    b0 = beats[ln];
    k0 = brk[ln];
    send_frame(ln, d, pb, s2);
    wait_clk(2 * BT);
    chk({nm, "_beats"}, beats[ln] - b0, 1);
    chk({nm, "_data"}, ldata[ln], ed);
    chk({nm, "_perr"}, lpe[ln], epe);
    chk({nm, "_ferr"}, lfe[ln], efe);
    chk({nm, "_nobrk"}, brk[ln] - k0, 0);
  endtask

  initial begin
    int b0, o0, k0;
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[2] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[3] = '{2, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{2, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[5] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[8] = '{1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[9] = '{0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};

    if0.rx_ready = 1'b1;
    if1.rx_ready = 1'b1;
    if2.rx_ready = 1'b1;

    // Reset state.
    wait_clk(5);
    chk("rst_valid0", if0.rx_valid, 0);
    chk("rst_valid1", if1.rx_valid, 0);
    chk("rst_data0", if0.rx_data, 0);
    chk("rst_ovr0", if0.overrun, 0);
    chk("rst_brk0", if0.break_det, 0);
    rst_n = 1'b1;
    wait_clk(2 * BT);

    for (int i = 0; i < 10; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].ln, vecs[i].d, vecs[i].pb, vecs[i].s2,
                vecs[i].ed, vecs[i].epe, vecs[i].efe);
    end

    // Short low glitch: false start, nothing delivered, FSM back in IDLE.
    b0 = beats[0];
    rxd[0] = 1'b0;
    wait_clk(4);
    rxd[0] = 1'b1;
    wait_clk(3 * BT);
    chk("glitch_beats", beats[0] - b0, 0);
    chk("glitch_idle", 32'(dut0.state_r), 0);
    run_frame("after_glitch", 0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0);

    // Overrun: second word dropped while the first is held.
    if0.rx_ready = 1'b0;
    b0 = beats[0];
    o0 = ovr[0];
    send_frame(0, 8'h11, 1'b0, 1'b1);
    wait_clk(BT);
    chk("ovr_first_valid", if0.rx_valid, 1);
    chk("ovr_no_pulse_yet", ovr[0] - o0, 0);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    wait_clk(BT);
    chk("ovr_pulses", ovr[0] - o0, 1);
    chk("ovr_held_valid", if0.rx_valid, 1);
    chk("ovr_held_data", if0.rx_data, 8'h11);
    chk("ovr_no_beat", beats[0] - b0, 0);
    if0.rx_ready = 1'b1;
    wait_clk(2);
    chk("ovr_accept_beat", beats[0] - b0, 1);
    chk("ovr_accept_data", ldata[0], 8'h11);
    chk("ovr_valid_clear", if0.rx_valid, 0);

    // Break: 30 bit times low gives one pulse and no word.
    b0 = beats[0];
    k0 = brk[0];
    rxd[0] = 1'b0;
    wait_clk(30 * BT);
    rxd[0] = 1'b1;
    wait_clk(2 * BT);
    chk("brk_pulses", brk[0] - k0, 1);
    chk("brk_no_beat", beats[0] - b0, 0);
    chk("brk_idle", 32'(dut0.state_r), 0);
    run_frame("after_brk", 0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);

    // Async reset in the middle of the data bits aborts the frame.
    b0 = beats[0];
    fork
      send_frame(0, 8'hC3, 1'b0, 1'b1);
      begin
        wait_clk(4 * BT);
        rst_n = 1'b0;
        wait_clk(2);
        chk("midrst_valid", if0.rx_valid, 0);
        wait_clk(8 * BT);
        rst_n = 1'b1;
      end
    join
    wait_clk(2 * BT);
    chk("midrst_no_beat", beats[0] - b0, 0);
    run_frame("after_rst", 0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
